// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: per-FU one-entry holding slots, round-robin
// grant, registered single write port into the integer PRF.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   src_valid     per-source result valid
//   src_ready     per-source accept (state-only, no path from src_valid)
//   src_rd_addr   packed dest preg, source k at [k*PREG_IDX_W +: PREG_IDX_W]
//   src_rd_data   packed result data, same packing
//   wb_we         registered PRF write enable, also the wakeup strobe
//   wb_addr       registered PRF write index / wakeup tag
//   wb_data       registered PRF write data
//   conflict_cnt  saturating count of cycles with two or more slots valid

`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module int_wb_arbiter #(
    parameter int NUM_SRC      = 3,
    parameter int PREG_IDX_W   = `PREG_IDX_WIDTH,
    parameter int DATA_W       = `DATA_WIDTH,
    parameter bit ZERO_PREG_EN = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*PREG_IDX_W-1:0] src_rd_addr,
    input  logic [NUM_SRC*DATA_W-1:0]     src_rd_data,
    output logic                          wb_we,
    output logic [PREG_IDX_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]             wb_data,
    output logic [CNT_W-1:0]              conflict_cnt
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

    logic [NUM_SRC-1:0]    slot_v;
    logic [PREG_IDX_W-1:0] slot_addr [NUM_SRC];
    logic [DATA_W-1:0]     slot_data [NUM_SRC];
    logic [PTR_W-1:0]      rr_ptr;

    logic [NUM_SRC-1:0]    grant;
    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic [PREG_IDX_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [NUM_SRC-1:0]    accept;
    logic [NUM_SRC-1:0]    drop;
    logic                  conflict;

    // rr_ptr + offset, folded back into 0..NUM_SRC-1 without a divider.
    function automatic int wrap_idx(input int v);
        return (v >= NUM_SRC) ? v - NUM_SRC : v;
    endfunction

    // Scan slots starting at rr_ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!grant_any && slot_v[k] &&
                    (k == wrap_idx(int'(rr_ptr) + i))) begin
                    grant[k]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(k);
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant[k]) begin
                sel_addr = slot_addr[k];
                sel_data = slot_data[k];
            end
        end
    end

    // A granted slot drains this cycle, so it can take a new entry now.
    assign src_ready = ~slot_v | grant;

    always_comb begin
        accept = '0;
        drop   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            accept[k] = src_valid[k] & src_ready[k];
            drop[k]   = ZERO_PREG_EN &&
                        (src_rd_addr[k*PREG_IDX_W +: PREG_IDX_W] == '0);
        end
    end

    assign conflict = ($countones(slot_v) > 1);

    // Dropped preg-0 results never occupy a slot; a grant without a
    // storing accept empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v <= '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                slot_addr[k] <= '0;
                slot_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (accept[k] && !drop[k]) begin
                    slot_v[k]    <= 1'b1;
                    slot_addr[k] <= src_rd_addr[k*PREG_IDX_W +: PREG_IDX_W];
                    slot_data[k] <= src_rd_data[k*DATA_W +: DATA_W];
                end else if (grant[k]) begin
                    slot_v[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Address/data hold on idle cycles; only wb_we marks a real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= grant_any;
            if (grant_any) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
